// File: rtl/matrix_ram_reader.sv
// matrix_ram_reader
// Reads the A and B matrices out of the fluxo_ram pair. Both RAMs share one
// address, so each address yields one element pair. The pairs go to the
// arithmetic core over a valid/ready stream and carry their row/col tags.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   start               single-cycle request to begin a pass (ignored while busy)
//   busy, done          pass in progress / one-cycle completion pulse
//   endereco, grava     shared RAM read address / RAM write enable (always 0)
//   dado_a, dado_b      RAM read data, valid the cycle after the address
//   out_valid/out_ready output handshake
//   out_a, out_b        element pair
//   out_row, out_col    element position inside the 5x5 matrix
//   out_last            marks the final element of the pass
module matrix_ram_reader #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8,
    parameter int N_ELEM = 25,
    parameter int COLS   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] endereco,
    output logic              grava,
    input  logic [DATA_W-1:0] dado_a,
    input  logic [DATA_W-1:0] dado_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last
);

    localparam int EW = 2*DATA_W + 7;
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM-1);
    localparam logic [ADDR_W-1:0] END_IDX  = ADDR_W'(N_ELEM);
    localparam logic [2:0]        LAST_COL = 3'(COLS-1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] counter;
    logic [2:0]        iss_row;
    logic [2:0]        iss_col;

    // Tags of the read whose data appears on dado_a/dado_b this cycle.
    logic              inflight;
    logic [2:0]        inf_row;
    logic [2:0]        inf_col;
    logic              inf_last;

    // Two-entry skid buffer; buf0 is the head.
    logic [EW-1:0]     buf0;
    logic [EW-1:0]     buf1;
    logic [1:0]        occ;

    logic [EW-1:0]     ram_entry;
    logic [EW-1:0]     head;
    logic [1:0]        entries;
    logic [1:0]        remain;
    logic              pop;
    logic              issue;
    logic              issue_last;

    assign grava = 1'b0;

    // The in-flight read counts as a queue entry behind the buffer. If the
    // buffer is empty, the RAM data goes straight to the output. This bypass
    // gives the 2-cycle start-to-valid latency without an extra register stage.
    assign ram_entry = {dado_a, dado_b, inf_row, inf_col, inf_last};
    assign entries   = occ + {1'b0, inflight};
    assign out_valid = (entries != 2'd0);
    assign pop       = out_valid && out_ready;
    assign remain    = entries - {1'b0, pop};

    // A read may be issued only if its data will find a free slot. This
    // keeps buffered entries plus in-flight reads at two or fewer.
    assign issue      = (state == READ) && (remain < 2'd2);
    assign issue_last = (counter == LAST_IDX);

    // After the last issue the counter parks at N_ELEM. The address stays
    // clamped to the final element so it never leaves the matrix.
    assign endereco = (counter >= END_IDX) ? LAST_IDX : counter;

    always_comb begin
        head = '0;
        if (occ != 2'd0) begin
            head = buf0;
        end else if (inflight) begin
            head = ram_entry;
        end
    end

    assign {out_a, out_b, out_row, out_col, out_last} = head;

    // Buffer update. Whatever is in flight and not consumed this cycle moves
    // into the next free slot, and a pop shifts buf1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0 <= '0;
            buf1 <= '0;
            occ  <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (inflight && !pop) begin
                        buf0 <= ram_entry;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop) begin
                        if (inflight) begin
                            buf0 <= ram_entry;
                        end else begin
                            occ <= 2'd0;
                        end
                    end else if (inflight) begin
                        buf1 <= ram_entry;
                        occ  <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        buf0 <= buf1;
                        occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Pass sequencing. Row/col are counted in lockstep with the issue index
    // to avoid a divider. A start in the done cycle is ignored, so a pass
    // cannot restart before the completion pulse has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            counter  <= '0;
            iss_row  <= 3'd0;
            iss_col  <= 3'd0;
            inflight <= 1'b0;
            inf_row  <= 3'd0;
            inf_col  <= 3'd0;
            inf_last <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                inf_row  <= iss_row;
                inf_col  <= iss_col;
                inf_last <= issue_last;
                counter  <= counter + ONE;
                if (iss_col == LAST_COL) begin
                    iss_col <= 3'd0;
                    iss_row <= iss_row + 3'd1;
                end else begin
                    iss_col <= iss_col + 3'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state   <= READ;
                        busy    <= 1'b1;
                        counter <= '0;
                        iss_row <= 3'd0;
                        iss_col <= 3'd0;
                    end
                end
                READ: begin
                    if (issue && issue_last) begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    if (remain == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_ram_reader.sv
// tb_matrix_ram_reader
// Scoreboard bench for matrix_ram_reader. Every accepted start queues the 25
// expected pairs, computed from the RAM contents. The row is index/5 and the
// col is index%5. A negedge monitor pops the queue on each handshake and also
// checks busy/done timing, stall stability, the address range and the limit on
// outstanding reads.
module tb_matrix_ram_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] endereco;
    logic       grava;
    logic [8:0] dado_a;
    logic [8:0] dado_b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_a;
    logic [8:0] out_b;
    logic [2:0] out_row;
    logic [2:0] out_col;
    logic       out_last;

    matrix_ram_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .endereco(endereco), .grava(grava), .dado_a(dado_a), .dado_b(dado_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM pair.
    logic [8:0] mem_a [0:255];
    logic [8:0] mem_b [0:255];

    always @(posedge clk) begin
        dado_a <= mem_a[endereco];
        dado_b <= mem_b[endereco];
    end

    typedef struct {
        int a;
        int b;
        int row;
        int col;
        int last;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = -100;
    int last_hs_cyc = -100;
    int hs_count = 0;
    bit pass_active = 1'b0;
    int ready_mode = 0;
    int phase = 0;

    logic        prev_stall = 1'b0;
    logic [25:0] prev_pack = '0;

    always @(posedge clk) cyc++;

    // out_ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 held low.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        phase++;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: comparisons against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t        e;
            logic [25:0] cur_pack;
            checkOutput("grava", int'(grava), 0);
            checkOutput("addr_range", int'(endereco <= 8'd24), 1);
            checkOutput("busy", int'(busy), int'(pass_active && (cyc > start_cyc)));
            checkOutput("done", int'(done), int'(cyc == last_hs_cyc + 1));
            if (pass_active && (cyc > start_cyc) && (endereco < 8'd24)) begin
                checkOutput("outstanding_le2", int'((int'(endereco) - hs_count) <= 2), 1);
            end
            cur_pack = {out_valid, out_a, out_b, out_row, out_col, out_last};
            if (prev_stall) begin
                checkOutput("stall_hold", int'(cur_pack == prev_pack), 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_pack  = cur_pack;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pair", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_a", int'(out_a), e.a);
                    checkOutput("out_b", int'(out_b), e.b);
                    checkOutput("out_row", int'(out_row), e.row);
                    checkOutput("out_col", int'(out_col), e.col);
                    checkOutput("out_last", int'(out_last), e.last);
                    if (e.cyc >= 0) checkOutput("pair_cycle", cyc, e.cyc);
                    hs_count++;
                    if (e.last != 0) begin
                        pass_active = 1'b0;
                        last_hs_cyc = cyc;
                    end
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic loadPreset();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = (i < 25) ? 9'(i + 1) : 9'd0;
            mem_b[i] = (i < 25) ? 9'(i + 26) : 9'd0;
        end
    endtask

    task automatic loadRandom();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 9'($urandom_range(0, 511));
            mem_b[i] = 9'($urandom_range(0, 511));
        end
    endtask

    // Pulses start for one cycle; the model decides whether it is accepted.
    task automatic applyStimulus(input bit timed);
        bit accepted;
        accepted = !pass_active && (cyc != last_hs_cyc + 1);
        if (accepted) begin
            pass_active = 1'b1;
            start_cyc   = cyc;
            hs_count    = 0;
            for (int i = 0; i < 25; i++) begin
                exp_t e;
                e.a = int'(mem_a[i]);
                e.b = int'(mem_b[i]);
                e.row = i / 5;
                e.col = i % 5;
                e.last = (i == 24) ? 1 : 0;
                e.cyc = timed ? (cyc + 2 + i) : -1;
                sb.push_back(e);
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns in the cycle after the final handshake, which is the done cycle.
    task automatic waitPassDone();
        int n;
        n = 0;
        while (pass_active && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (pass_active) begin
            checkOutput("pass_timeout", 1, 0);
            pass_active = 1'b0;
            sb.delete();
        end
    endtask

    task automatic waitHandshakes(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hs_count < target) checkOutput("hs_timeout", hs_count, target);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_addr"}, int'(endereco), 0);
        checkOutput({tag, "_data"}, int'({out_a, out_b, out_row, out_col, out_last}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        loadPreset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full-speed pass with preset contents and exact timing.
        ready_mode = 0;
        applyStimulus(1'b1);
        waitPassDone();
        repeat (3) @(posedge clk);
        #1;

        // Fixed 1,0,0,1 backpressure, then random backpressure on random data.
        loadRandom();
        ready_mode = 1;
        phase = 0;
        applyStimulus(1'b0);
        waitPassDone();
        repeat (2) @(posedge clk);
        #1;
        loadRandom();
        ready_mode = 2;
        applyStimulus(1'b0);
        waitPassDone();
        repeat (2) @(posedge clk);
        #1;

        // Consumer stalled right after start: only two reads may be issued.
        loadPreset();
        ready_mode = 3;
        applyStimulus(1'b0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("stuck_addr", int'(endereco), 2);
        ready_mode = 0;
        waitPassDone();
        repeat (2) @(posedge clk);
        #1;

        // Starts while busy and on the done cycle must be ignored.
        applyStimulus(1'b0);
        waitHandshakes(10);
        applyStimulus(1'b0);
        waitPassDone();
        applyStimulus(1'b0);
        repeat (30) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a pass.
        applyStimulus(1'b0);
        waitHandshakes(12);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        pass_active = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1);
        waitPassDone();
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back passes: second start lands the cycle after done.
        applyStimulus(1'b1);
        waitPassDone();
        @(posedge clk);
        #1;
        applyStimulus(1'b1);
        waitPassDone();
        repeat (3) @(posedge clk);
        #1;

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
